// File: rtl/cg_amp_scheduler.sv
// Common-gate amplifier stage scheduler.
// Two requesters share one common-gate stage. A grant biases the pmos load,
// waits for the bias to settle, opens the input switch for the sample window,
// then releases for one cycle to pulse done (or abort if the owner let go early).
// Every output comes straight from a flop; all decode works on next-state values.
module cg_amp_scheduler #(
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       bias_n,
  output logic       in_en,
  output logic       sample,
  output logic [1:0] done,
  output logic       abort,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, BIAS, SAMP, REL} state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] SAMPLE_LD = 8'(SAMPLE_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;   // preferred requester when both ask
  logic       win_q, win_d;   // index of current owner
  logic       ab_d;           // grant is ending early

  logic [1:0] grant_q, grant_d;
  logic       bias_n_q, bias_n_d;
  logic       in_en_q, in_en_d;
  logic       sample_q, sample_d;
  logic [1:0] done_q, done_d;
  logic       abort_q;
  logic       busy_q, busy_d;

  // Next-state, counter, pointer and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    ab_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (req != 2'b00) begin
          // Single requester wins outright; contention goes to the pointer.
          win_d   = (req == 2'b11) ? ptr_q : req[1];
          state_d = BIAS;
          cnt_d   = SETTLE_LD;
        end
      end
      BIAS: begin
        if (!req[win_q]) begin
          state_d = REL;
          ab_d    = 1'b1;
          ptr_d   = ~win_q;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = SAMP;
          cnt_d   = SAMPLE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SAMP: begin
        // A dropped request wins over a simultaneous natural end of window.
        if (!req[win_q]) begin
          state_d = REL;
          ab_d    = 1'b1;
          ptr_d   = ~win_q;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = REL;
          ptr_d   = ~win_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      REL: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    grant_d  = (state_d != IDLE) ? (win_d ? 2'b10 : 2'b01) : 2'b00;
    bias_n_d = !(state_d == BIAS || state_d == SAMP);
    in_en_d  = (state_d == SAMP);
    sample_d = (state_d == SAMP);
    done_d   = (state_d == REL && !ab_d) ? grant_d : 2'b00;
    busy_d   = (state_d != IDLE);
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      ptr_q    <= 1'b0;
      win_q    <= 1'b0;
      grant_q  <= 2'b00;
      bias_n_q <= 1'b1;
      in_en_q  <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 2'b00;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      bias_n_q <= bias_n_d;
      in_en_q  <= in_en_d;
      sample_q <= sample_d;
      done_q   <= done_d;
      abort_q  <= ab_d;
      busy_q   <= busy_d;
    end
  end

  assign grant  = grant_q;
  assign bias_n = bias_n_q;
  assign in_en  = in_en_q;
  assign sample = sample_q;
  assign done   = done_q;
  assign abort  = abort_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_cg_amp_scheduler.sv
// Scoreboard bench: two schedulers (default timing and 1/1 timing) driven with
// directed then random request levels; a grant-level model predicts per-cycle
// levels and completion events, a negedge monitor pops and compares.
module tb_cg_amp_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic [1:0][1:0] rq, g, dn;
  logic [1:0] bn, ie, sm, ab, bz;

  always #5 clk = ~clk;

  cg_amp_scheduler #(.SETTLE_CYC(8), .SAMPLE_CYC(4)) dut0 (
    .clk(clk), .rst(rst), .req(rq[0]), .grant(g[0]), .bias_n(bn[0]),
    .in_en(ie[0]), .sample(sm[0]), .done(dn[0]), .abort(ab[0]), .busy(bz[0]));

  cg_amp_scheduler #(.SETTLE_CYC(1), .SAMPLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .req(rq[1]), .grant(g[1]), .bias_n(bn[1]),
    .in_en(ie[1]), .sample(sm[1]), .done(dn[1]), .abort(ab[1]), .busy(bz[1]));

  typedef struct packed {
    logic [1:0][1:0] grant;
    logic [1:0] bias_n, in_en, sample, busy;
  } lvl_t;
  typedef struct packed { logic w; logic ab; } ev_t;

  lvl_t lq[$];
  ev_t  evq0[$], evq1[$];
  int   checks = 0, errors = 0;

  // Grant-level model: owner, age within grant, release/abort flags, pointer.
  int S[2] = '{8, 1};
  int P[2] = '{4, 1};
  bit mb[2], mrel[2], mw[2], mptr[2];
  int mage[2];

  task automatic push_ev(input int k, input bit w, input bit a);
    ev_t e;
    e.w = w; e.ab = a;
    if (k == 0) evq0.push_back(e); else evq1.push_back(e);
  endtask

  task automatic step(input int k, input bit r_st, input logic [1:0] r);
    if (r_st) begin
      mb[k] = 0; mrel[k] = 0; mptr[k] = 0;
    end else if (!mb[k]) begin
      if (r != 2'b00) begin
        mw[k]   = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : mptr[k];
        mb[k]   = 1; mage[k] = 1; mrel[k] = 0;
      end
    end else if (mrel[k]) begin
      mb[k] = 0; mrel[k] = 0;
    end else if (!r[mw[k]]) begin
      mrel[k] = 1; mptr[k] = !mw[k]; push_ev(k, mw[k], 1'b1);
    end else if (mage[k] == S[k] + P[k]) begin
      mrel[k] = 1; mptr[k] = !mw[k]; push_ev(k, mw[k], 1'b0);
    end else begin
      mage[k]++;
    end
  endtask

  // Apply inputs for the coming edge and record the predicted post-edge levels.
  task automatic apply(input bit r_st, input logic [1:0] r0, input logic [1:0] r1);
    lvl_t e;
    rst = r_st; rq[0] = r0; rq[1] = r1;
    step(0, r_st, r0);
    step(1, r_st, r1);
    for (int k = 0; k < 2; k++) begin
      e.grant[k]  = mb[k] ? (mw[k] ? 2'b10 : 2'b01) : 2'b00;
      e.bias_n[k] = !(mb[k] && !mrel[k]);
      e.in_en[k]  = mb[k] && !mrel[k] && (mage[k] > S[k]);
      e.sample[k] = e.in_en[k];
      e.busy[k]   = mb[k];
    end
    lq.push_back(e);
  endtask

  task automatic cyc(input bit r_st, input logic [1:0] r0, input logic [1:0] r1);
    @(posedge clk); #1;
    apply(r_st, r0, r1);
  endtask

  // Monitor: per-cycle levels, safety properties, and completion events.
  always @(negedge clk) begin
    lvl_t e;
    ev_t  ev;
    bit   have;
    if (lq.size() > 0) begin
      e = lq.pop_front();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({g[k], bn[k], ie[k], sm[k], bz[k]} !==
            {e.grant[k], e.bias_n[k], e.in_en[k], e.sample[k], e.busy[k]}) begin
          errors++;
          $display("FAIL levels dut%0d t=%0t got g/bn/ie/sm/bz=%b_%b%b%b%b want %b_%b%b%b%b",
                   k, $time, g[k], bn[k], ie[k], sm[k], bz[k], e.grant[k],
                   e.bias_n[k], e.in_en[k], e.sample[k], e.busy[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (bz[k] !== 1'bx) begin
        checks++;
        if ((ie[k] && (bn[k] || !$onehot(g[k]))) || (dn[k] != 2'b00 && ab[k])) begin
          errors++;
          $display("FAIL safety dut%0d t=%0t got ie=%b bn=%b g=%b dn=%b ab=%b",
                   k, $time, ie[k], bn[k], g[k], dn[k], ab[k]);
        end
      end
      if (dn[k] != 2'b00 || ab[k]) begin
        have = 0;
        if (k == 0) begin
          if (evq0.size() > 0) begin have = 1; ev = evq0.pop_front(); end
        end else begin
          if (evq1.size() > 0) begin have = 1; ev = evq1.pop_front(); end
        end
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL event dut%0d t=%0t got dn=%b ab=%b want no event", k, $time, dn[k], ab[k]);
        end else if ({g[k], dn[k], ab[k]} !==
                     {(ev.w ? 2'b10 : 2'b01), (ev.ab ? 2'b00 : (ev.w ? 2'b10 : 2'b01)), ev.ab}) begin
          errors++;
          $display("FAIL event dut%0d t=%0t got g=%b dn=%b ab=%b want owner=%0d abort=%0d",
                   k, $time, g[k], dn[k], ab[k], ev.w, ev.ab);
        end
      end
    end
  end

  initial begin
    logic [1:0] r0, r1;
    apply(1'b1, 2'b00, 2'b00);
    repeat (3) cyc(1'b1, 2'b00, 2'b00);
    // Single requester each: full grants, back-to-back regrant of same owner.
    repeat (20) cyc(1'b0, 2'b01, 2'b10);
    repeat (3)  cyc(1'b0, 2'b00, 2'b00);
    // Contention: alternate owners with one idle cycle between.
    repeat (60) cyc(1'b0, 2'b11, 2'b11);
    repeat (3)  cyc(1'b0, 2'b00, 2'b00);
    // Drop during BIAS, then contention shows pointer moved.
    repeat (5)  cyc(1'b0, 2'b01, 2'b01);
    repeat (2)  cyc(1'b0, 2'b00, 2'b00);
    repeat (30) cyc(1'b0, 2'b11, 2'b11);
    repeat (3)  cyc(1'b0, 2'b00, 2'b00);
    // Reset mid-grant.
    repeat (10) cyc(1'b0, 2'b01, 2'b10);
    cyc(1'b1, 2'b01, 2'b10);
    repeat (4)  cyc(1'b0, 2'b00, 2'b00);
    // Random request levels with occasional resets.
    r0 = 2'b00; r1 = 2'b00;
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) r0 = r0 ^ (2'b01 << $urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)  r1 = r1 ^ (2'b01 << $urandom_range(0, 1));
      cyc($urandom_range(0, 399) == 0, r0, r1);
    end
    repeat (20) cyc(1'b0, 2'b00, 2'b00);
    @(negedge clk); #1;
    checks++;
    if (evq0.size() != 0 || evq1.size() != 0) begin
      errors++;
      $display("FAIL drain got pending events %0d/%0d want 0/0", evq0.size(), evq1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cg_amp_scheduler.md
CG_AMP_SCHEDULER -- requirements
Module: cg_amp_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter SETTLE_CYC, default 8, SHALL set the bias-settle cycles per grant, with legal range 1..255.
REQ-003 Parameter SAMPLE_CYC, default 4, SHALL set the sample-window cycles per grant, with legal range 1..255.
REQ-004 clk  input  1  SHALL be the sole clock.
REQ-005 rst  input  1  SHALL be the synchronous active-high reset.
REQ-006 req  input  2  SHALL be the per-requester level request for the shared common-gate stage.
REQ-007 grant  output  2  SHALL be the one-hot owner of the stage, or all-zero when idle.
REQ-008 bias_n  output  1  SHALL drive the pmos load gate, active-low: 0 = load biased on.
REQ-009 in_en  output  1  SHALL enable the nmos input/source switch onto in1.
REQ-010 sample  output  1  SHALL be a level that is high while the output node is valid to capture.
REQ-011 done  output  2  SHALL be a one-cycle completion pulse to the granted requester.
REQ-012 abort  output  1  SHALL be a one-cycle pulse when a grant ends early because its request was dropped.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-014 The state machine SHALL have four states: IDLE, BIAS, SAMP and REL.
REQ-015 In IDLE with any req bit high, the next state SHALL be BIAS and grant SHALL be set to the winner in that same transition.
REQ-016 Arbitration SHALL be round-robin using a 1-bit pointer.
REQ-017 If only one request is high, that requester SHALL win.
REQ-018 If both requests are high, the requester selected by the pointer SHALL win.
REQ-019 On entering REL, the pointer SHALL move to the non-winning requester.
REQ-020 BIAS SHALL last exactly SETTLE_CYC cycles, with bias_n=0, in_en=0 and sample=0; the block SHALL then enter SAMP.
REQ-021 SAMP SHALL last exactly SAMPLE_CYC cycles, with bias_n=0, in_en=1 and sample=1; the block SHALL then enter REL.
REQ-022 REL SHALL last exactly 1 cycle, with bias_n=1, in_en=0, sample=0 and grant held.
REQ-023 In REL, done[winner] SHALL be 1 unless the grant is aborting; the block SHALL return to IDLE after REL.
REQ-024 grant SHALL be constant from BIAS entry through REL and SHALL be zero in IDLE.
REQ-025 grant, bias_n, in_en, sample, done and abort SHALL be registered outputs with no combinational path from req.
REQ-026 A single 8-bit down-counter SHALL be used.
REQ-027 On entry to BIAS, the counter SHALL load SETTLE_CYC-1; on entry to SAMP, it SHALL load SAMPLE_CYC-1.
REQ-028 The counter SHALL advance to the next state when it reaches 0 and SHALL never wrap.
REQ-029 If req[winner] is low in BIAS or SAMP, the next state SHALL be REL with abort=1 and done=0 in REL.
REQ-030 After an abort, the pointer SHALL still advance.
REQ-031 At least one IDLE cycle SHALL separate consecutive grants.
REQ-032 A request arriving during a grant SHALL be held off until IDLE.
REQ-033 A requester that keeps req high after its done pulse SHALL be granted again only if the other req is low.
REQ-034 in_en SHALL never be 1 while bias_n=1, so the input switch never closes on an unbiased stage.
REQ-035 bias_n SHALL fall no later than the grant, and in_en SHALL rise at least SETTLE_CYC cycles after bias_n falls.

Reset
REQ-036 While rst=1 at a clock edge, the next state SHALL be IDLE with the counter at 0 and the pointer at 0 (req[0] preferred).
REQ-037 During reset, the outputs SHALL be: grant=00, bias_n=1, in_en=0, sample=0, done=00, abort=0, busy=0.
REQ-038 Reset asserted mid-grant in any state SHALL drop the grant and bias on the next edge with no done or abort pulse.
REQ-039 Reset SHALL take priority over every other transition.

Verification
REQ-040 With SETTLE=8, SAMPLE=4, req=01 from cycle 0 (post-reset) -> grant=01 for cycles 1-13; bias_n=0 for cycles 1-12; in_en=sample=1 for cycles 9-12; done=01 at cycle 13; busy=0 at cycle 14.
REQ-041 With both requesters held at req=11 -> grants SHALL alternate 01,10,01,10, each 13 cycles long with 1 IDLE cycle between grants; done SHALL pulse once per grant.
REQ-042 With req=01 dropped during BIAS at cycle 5 -> REL at cycle 6 with abort=1 and done=00; IDLE at cycle 7; the pointer SHALL then favour req[1].
REQ-043 With rst pulsed at cycle 10 of an active grant -> grant=00, bias_n=1 and in_en=0 at cycle 11; no done or abort pulse SHALL occur.
REQ-044 With SETTLE=1, SAMPLE=1, req=10 -> BIAS for 1 cycle, SAMP for 1 cycle, REL for 1 cycle (done=10 in REL); grant SHALL last 3 cycles total.
REQ-045 For the whole random run, an assertion SHALL hold: in_en=1 implies bias_n=0 and a one-hot grant, and done and abort are never both set.
